rv32i_instruction_encoder: RTL and testbench

Streaming RV32I instruction encoder and program writer, the inverse of the base-integer/Zihintpause decoder. It accepts instruction fields (format, opcode, fn3, fn7, register indices, 32-bit immediate) over a valid/ready handshake and packs them into a 32-bit instruction word. Immediate ranges are checked. Words go through a 2-entry buffer and are written to instruction memory at consecutive word addresses. It is used by the boot/program loader and by the testbench to build instruction images.

---
 rtl/rv32i_instruction_encoder.sv | 164 ++++++++++++++++
 tb/tb_rv32i_instruction_encoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module  : rv32i_instruction_encoder
// Brief   : Packs RV32I field bundles into instruction words, range-checks the
//           immediates, and streams the words to instruction memory through a
//           2-entry buffer.
// Revision: 1.0 - initial release
// ============================================================================
module rv32i_instruction_encoder #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            code,
  input  logic [2:0]            fn3,
  input  logic [6:0]            fn7,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  mem_w,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  input  logic                  mem_ready,
  output logic                  imm_err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wrapped
);

  localparam logic [1:0]            S_EMPTY    = 2'd0;
  localparam logic [1:0]            S_ONE      = 2'd1;
  localparam logic [1:0]            S_FULL     = 2'd2;
  localparam logic [31:0]           PAUSE_WORD = 32'h0100_000F;
  localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   CNT_MAX    = {(ADDR_WIDTH+1){1'b1}};

  logic [1:0]            state_q, state_d;
  logic [31:0]           ent0_word_q, ent1_word_q;
  logic                  ent0_err_q, ent1_err_q;
  logic [ADDR_WIDTH-1:0] addr_q, err_addr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  imm_err_q, wrapped_q;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        push, pop, start_ok;

  always_comb begin
    enc_word = 32'h0;
    enc_err  = 1'b0;
    case (fmt)
      3'd0: enc_word = {fn7, rs2, rs1, fn3, rd, code};
      3'd1: begin
        enc_word = {imm[11:0], rs1, fn3, rd, code};
        enc_err  = !((&imm[31:11]) || (imm[31:11] == 21'd0));
      end
      3'd2: begin
        enc_word = {imm[11:5], rs2, rs1, fn3, imm[4:0], code};
        enc_err  = !((&imm[31:11]) || (imm[31:11] == 21'd0));
      end
      3'd3: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, fn3, imm[4:1], imm[11], code};
        enc_err  = imm[0] || !((&imm[31:12]) || (imm[31:12] == 20'd0));
      end
      3'd4: begin
        enc_word = {imm[31:12], rd, code};
        enc_err  = |imm[11:0];
      end
      3'd5: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, code};
        enc_err  = imm[0] || !((&imm[31:20]) || (imm[31:20] == 12'd0));
      end
      3'd6: begin
        enc_word = {fn7, imm[4:0], rs1, fn3, rd, code};
        enc_err  = |imm[31:5];
      end
      default: enc_word = PAUSE_WORD;
    endcase
  end

  // Buffer FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (push) state_d = S_ONE;
      S_ONE: begin
        if (push && !pop)      state_d = S_FULL;
        else if (pop && !push) state_d = S_EMPTY;
      end
      S_FULL:  if (pop) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    in_ready = rst_n && (state_q != S_FULL);
    mem_w    = (state_q != S_EMPTY);
  end

  assign push     = in_valid && in_ready;
  assign pop      = mem_w && mem_ready;
  assign start_ok = start && (state_q == S_EMPTY) && !in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent0_word_q <= 32'h0;
      ent0_err_q  <= 1'b0;
      ent1_word_q <= 32'h0;
      ent1_err_q  <= 1'b0;
      addr_q      <= BASE;
      count_q     <= '0;
      imm_err_q   <= 1'b0;
      err_addr_q  <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      // Head is entry 0; a push lands at the head whenever the head is free this edge
      if (state_q == S_FULL && pop) begin
        ent0_word_q <= ent1_word_q;
        ent0_err_q  <= ent1_err_q;
      end else if (push && (state_q == S_EMPTY || pop)) begin
        ent0_word_q <= enc_word;
        ent0_err_q  <= enc_err;
      end else if (push) begin
        ent1_word_q <= enc_word;
        ent1_err_q  <= enc_err;
      end
      if (pop) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        if (&addr_q) wrapped_q <= 1'b1;
        if (count_q != CNT_MAX) count_q <= count_q + (ADDR_WIDTH+1)'(1);
        if (ent0_err_q && !imm_err_q) begin
          imm_err_q  <= 1'b1;
          err_addr_q <= addr_q;
        end
      end
      if (start_ok) begin
        addr_q    <= BASE;
        count_q   <= '0;
        imm_err_q <= 1'b0;
        wrapped_q <= 1'b0;
      end
    end
  end

  assign mem_data = ent0_word_q;
  assign mem_addr = addr_q;
  assign imm_err  = imm_err_q;
  assign err_addr = err_addr_q;
  assign count    = count_q;
  assign wrapped  = wrapped_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv32i_instruction_encoder
// Brief   : Directed and random stimulus against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rv32i_instruction_encoder;

  localparam int AW   = 3;
  localparam int BASE = 2;
  localparam int AMAX = (1 << AW) - 1;
  localparam int CMAX = (1 << (AW + 1)) - 1;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_ready, mem_w, mem_ready, imm_err, wrapped;
  logic [2:0]    fmt, fn3;
  logic [6:0]    code, fn7;
  logic [4:0]    rd, rs1, rs2;
  logic [31:0]   imm, mem_data;
  logic [AW-1:0] mem_addr, err_addr;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  rv32i_instruction_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .code(code), .fn3(fn3), .fn7(fn7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .mem_w(mem_w), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .imm_err(imm_err), .err_addr(err_addr), .count(count),
    .wrapped(wrapped)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] q_word[$];
  bit          q_bad[$];
  int          m_addr, m_count, m_err_addr;
  bit          m_err, m_wrapped, m_ok, acc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference encoder: field placement by shift/mask, range by signed value.
  function automatic void ref_enc(input logic [31:0] f, c, f3, f7, d, s1, s2, im,
                                  output logic [31:0] w, output bit bad);
    longint s = longint'($signed(im));
    logic [31:0] low = (s1 << 15) | (f3 << 12) | (d << 7) | c;
    bad = 1'b0;
    case (f)
      0: w = (f7 << 25) | (s2 << 20) | low;
      1: begin w = ((im & 32'hFFF) << 20) | low; bad = (s < -2048) || (s > 2047); end
      2: begin
        w = (((im >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) |
            ((im & 32'h1F) << 7) | c;
        bad = (s < -2048) || (s > 2047);
      end
      3: begin
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (s2 << 20) |
            (s1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7) | c;
        bad = (im[0] != 1'b0) || (s < -4096) || (s > 4095);
      end
      4: begin w = (im & 32'hFFFFF000) | (d << 7) | c; bad = (im & 32'hFFF) != 0; end
      5: begin
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
            (((im >> 11) & 1) << 20) | (im & 32'h000FF000) | (d << 7) | c;
        bad = (im[0] != 1'b0) || (s < -1048576) || (s > 1048575);
      end
      6: begin w = (f7 << 25) | ((im & 32'h1F) << 20) | low; bad = im > 32'd31; end
      default: w = 32'h0100000F;
    endcase
  endfunction

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic cycle();
    logic [31:0] w;
    bit bad, do_push, do_pop, do_start, rst_s;
    #3;
    if (m_ok) begin
      check("in_ready", in_ready, rst_n && q_word.size() < 2);
      check("mem_w", mem_w, q_word.size() > 0);
      if (q_word.size() > 0) begin
        check("mem_data", mem_data, q_word[0]);
        check("mem_addr", mem_addr, m_addr);
      end
      check("imm_err", imm_err, m_err);
      check("err_addr", err_addr, m_err_addr);
      check("count", count, m_count);
      check("wrapped", wrapped, m_wrapped);
    end
    ref_enc(fmt, code, fn3, fn7, rd, rs1, rs2, imm, w, bad);
    rst_s    = !rst_n;
    do_push  = rst_n && in_valid && q_word.size() < 2;
    do_pop   = q_word.size() > 0 && mem_ready;
    do_start = start && q_word.size() == 0 && !in_valid;
    @(posedge clk);
    acc = do_push;
    if (rst_s) begin
      q_word.delete(); q_bad.delete();
      m_addr = BASE; m_count = 0; m_err = 0; m_err_addr = 0; m_wrapped = 0;
    end else begin
      if (do_pop) begin
        if (q_bad[0] && !m_err) begin m_err = 1; m_err_addr = m_addr; end
        if (m_addr == AMAX) m_wrapped = 1;
        m_addr = (m_addr + 1) & AMAX;
        if (m_count < CMAX) m_count++;
        void'(q_word.pop_front()); void'(q_bad.pop_front());
      end
      if (do_push) begin q_word.push_back(w); q_bad.push_back(bad); end
      if (do_start) begin m_addr = BASE; m_count = 0; m_err = 0; m_wrapped = 0; end
    end
    m_ok = 1;
    #1;
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] c, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] d, s1, s2,
                            input logic [31:0] im);
    fmt = f; code = c; fn3 = f3; fn7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] c, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, s1, s2,
                      input logic [31:0] im);
    set_fields(f, c, f3, f7, d, s1, s2, im);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (acc) break;
    end
    check("send_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($signed($urandom_range(0, 8191)) - 4096);
      2:       return 32'($signed($urandom_range(0, 4095)) - 2048) << 1;
      default: return $urandom & 32'hFFFFF000;
    endcase
  endfunction

  initial begin
    int nacc;
    m_ok = 0; acc = 0;
    rst_n = 0; start = 0; in_valid = 0; mem_ready = 0;
    set_fields(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    rst_n = 1; mem_ready = 1;

    // ADD x3,x1,x2 / ADDI x1,x0,-1 / BEQ / JAL / PAUSE
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
    idle(3);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800);
    send(3'd7, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
         5'($urandom), $urandom);
    idle(3);

    // Backpressure: three back-to-back bundles, memory stalled at first
    mem_ready = 0; nacc = 0; in_valid = 1;
    for (int i = 0; i < 15 && nacc < 3; i++) begin
      set_fields(3'd0, 7'h33, 3'(nacc), 7'd0, 5'(nacc + 1), 5'd4, 5'd5, 32'h0);
      if (i == 5) mem_ready = 1;
      cycle();
      if (acc) nacc++;
    end
    check("bp_accepted", nacc, 3);
    in_valid = 0; mem_ready = 1;
    idle(4);

    // Out-of-range ADDI landing at address 5, then start clears the error
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 3; i++) send(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    idle(3);
    start = 1; cycle(); start = 0;
    idle(2);

    // Reset with a full buffer and stalled memory
    mem_ready = 0;
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'h12345000);
    send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    in_valid = 1; rst_n = 0; cycle(); rst_n = 1; in_valid = 0;
    idle(2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      start     = ($urandom_range(0, 19) == 0);
      mem_ready = ($urandom_range(0, 9) < 6);
      rst_n     = ($urandom_range(0, 299) != 0);
      set_fields(3'($urandom), 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom), rand_imm());
      cycle();
    end
    rst_n = 1; in_valid = 0; start = 0; mem_ready = 1;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
